// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Source indices, register address width and the x0 index.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_S0   = 2'd0,
    SRC_S1   = 2'd1,
    SRC_DBG  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: s0/s1/dbg requests, rf write port, fwd compare.
// master = requesters/consumer side, slave = arbiter side.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = 64
);

  logic            s0_valid;
  logic            s0_ready;
  reg_addr_t       s0_rd;
  logic [XLEN-1:0] s0_data;

  logic            s1_valid;
  logic            s1_ready;
  reg_addr_t       s1_rd;
  logic [XLEN-1:0] s1_data;

  logic            dbg_valid;
  logic            dbg_ready;
  reg_addr_t       dbg_rd;
  logic [XLEN-1:0] dbg_data;

  reg_addr_t       rf_rd;
  logic [XLEN-1:0] rf_rd_in;
  logic            rf_rd_we;

  reg_addr_t       fwd_rs1;
  reg_addr_t       fwd_rs2;
  logic            fwd_hit1;
  logic            fwd_hit2;

  modport master (
    output s0_valid, s0_rd, s0_data,
    output s1_valid, s1_rd, s1_data,
    output dbg_valid, dbg_rd, dbg_data,
    output fwd_rs1, fwd_rs2,
    input  s0_ready, s1_ready, dbg_ready,
    input  rf_rd, rf_rd_in, rf_rd_we,
    input  fwd_hit1, fwd_hit2
  );

  modport slave (
    input  s0_valid, s0_rd, s0_data,
    input  s1_valid, s1_rd, s1_data,
    input  dbg_valid, dbg_rd, dbg_data,
    input  fwd_rs1, fwd_rs2,
    output s0_ready, s1_ready, dbg_ready,
    output rf_rd, rf_rd_in, rf_rd_we,
    output fwd_hit1, fwd_hit2
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Two-way round-robin pick: one-hot grant from two requests and rr_ptr.
// rr_ptr=0 favours req0, rr_ptr=1 favours req1.
module wb_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req0 && req1):  gnt = rr_ptr ? 2'b10 : 2'b01;
      (req0 && !req1): gnt = 2'b01;
      (!req0 && req1): gnt = 2'b10;
      default:         gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: RR between s0/s1, starvation-guarded dbg.
// Optional WB_FWD_EN enables fwd_hit1/fwd_hit2 compare on the pending write.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic            rr_ptr;
  logic [7:0]      starve_cnt;
  logic            c0, c1, cd;
  logic            starve_hit;
  logic [1:0]      pick;
  logic            g_s0, g_s1, g_d, g_any;
  reg_addr_t       w_rd;
  logic [XLEN-1:0] w_data;
  reg_addr_t       rd_q;
  logic [XLEN-1:0] data_q;
  logic            we_q;

  // x0 requests are never contenders; they complete through ready alone
  assign c0 = bus.s0_valid  && (bus.s0_rd  != REG_ZERO);
  assign c1 = bus.s1_valid  && (bus.s1_rd  != REG_ZERO);
  assign cd = bus.dbg_valid && (bus.dbg_rd != REG_ZERO);

  assign starve_hit = cd && (starve_cnt == STARVE_LIM);

  wb_rr_pick u_pick (
    .req0   (c0),
    .req1   (c1),
    .rr_ptr (rr_ptr),
    .gnt    (pick)
  );

  assign g_d   = starve_hit || (cd && !c0 && !c1);
  assign g_s0  = pick[0] && !starve_hit;
  assign g_s1  = pick[1] && !starve_hit;
  assign g_any = g_s0 || g_s1 || g_d;

  assign bus.s0_ready  = (bus.s0_valid  && (bus.s0_rd  == REG_ZERO)) || g_s0;
  assign bus.s1_ready  = (bus.s1_valid  && (bus.s1_rd  == REG_ZERO)) || g_s1;
  assign bus.dbg_ready = (bus.dbg_valid && (bus.dbg_rd == REG_ZERO)) || g_d;

  always_comb begin
    w_rd   = REG_ZERO;
    w_data = '0;
    unique case (1'b1)
      g_s0: begin
        w_rd   = bus.s0_rd;
        w_data = bus.s0_data;
      end
      g_s1: begin
        w_rd   = bus.s1_rd;
        w_data = bus.s1_data;
      end
      g_d: begin
        w_rd   = bus.dbg_rd;
        w_data = bus.dbg_data;
      end
      default: begin
        w_rd   = REG_ZERO;
        w_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      rd_q       <= REG_ZERO;
      data_q     <= '0;
      rr_ptr     <= 1'b0;
      starve_cnt <= 8'd0;
    end else begin
      we_q <= g_any;
      if (g_any) begin
        rd_q   <= w_rd;
        data_q <= w_data;
      end
      if (g_s0) begin
        rr_ptr <= 1'b1;
      end else if (g_s1) begin
        rr_ptr <= 1'b0;
      end
      if (!cd || g_d) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  assign bus.rf_rd_we = we_q;
  assign bus.rf_rd    = rd_q;
  assign bus.rf_rd_in = data_q;

`ifdef WB_FWD_EN
  assign bus.fwd_hit1 = we_q && (rd_q == bus.fwd_rs1) && (bus.fwd_rs1 != REG_ZERO);
  assign bus.fwd_hit2 = we_q && (rd_q == bus.fwd_rs2) && (bus.fwd_rs2 != REG_ZERO);
`else
  logic unused_fwd;
  assign unused_fwd   = ^{bus.fwd_rs1, bus.fwd_rs2};
  assign bus.fwd_hit1 = 1'b0;
  assign bus.fwd_hit2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter with STARVE_MAX=3.
// Expected writes are queued on grant and popped when rf_rd_we appears.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;

`ifdef WB_FWD_EN
  localparam logic FWD_EXP = 1'b1;
`else
  localparam logic FWD_EXP = 1'b0;
`endif

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  wb_t  exp_q[$];
  wb_t  mon_e;
  logic [XLEN-1:0] shadow [32];

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (3)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rf_rd_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(bus.rf_rd_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_rd", 64'(bus.rf_rd), 64'(mon_e.rd));
        check("wb_data", bus.rf_rd_in, mon_e.data);
      end
      shadow[bus.rf_rd] = bus.rf_rd_in;
    end
  end

  task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rdy(input string tag, input logic e0,
                            input logic e1, input logic ed);
    @(negedge clk);
    check({tag, "_s0r"}, 64'(bus.s0_ready), 64'(e0));
    check({tag, "_s1r"}, 64'(bus.s1_ready), 64'(e1));
    check({tag, "_dbgr"}, 64'(bus.dbg_ready), 64'(ed));
  endtask

  task automatic idle_all();
    bus.s0_valid  = 1'b0;
    bus.s1_valid  = 1'b0;
    bus.dbg_valid = 1'b0;
  endtask

  task automatic push_src(input int s);
    case (s)
      0:       push(5'd5, 64'hA);
      1:       push(5'd6, 64'hB);
      default: push(5'd7, 64'h77);
    endcase
  endtask

  initial begin
    int alt_seq [5];
    alt_seq = '{0, 1, 0, 2, 1};
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst_n = 1'b0;
    idle_all();
    bus.s0_rd = '0;  bus.s0_data = '0;
    bus.s1_rd = '0;  bus.s1_data = '0;
    bus.dbg_rd = '0; bus.dbg_data = '0;
    bus.fwd_rs1 = '0;
    bus.fwd_rs2 = '0;
    #3;
    check("rst_we", 64'(bus.rf_rd_we), 64'd0);
    check("rst_rd", 64'(bus.rf_rd), 64'd0);
    check("rst_data", bus.rf_rd_in, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset while a write is on the port
    next_cyc();
    bus.s0_valid = 1'b1; bus.s0_rd = 5'd5; bus.s0_data = 64'hA5;
    expect_rdy("rst_xfer", 1'b1, 1'b0, 1'b0);
    next_cyc();
    idle_all();
    check("rst_we_pre", 64'(bus.rf_rd_we), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_we", 64'(bus.rf_rd_we), 64'd0);
    check("rst_async_rd", 64'(bus.rf_rd), 64'd0);
    next_cyc();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_we", 64'(bus.rf_rd_we), 64'd0);
    end

    // s0/s1 alternation, first grant proves rr_ptr reset to s0
    next_cyc();
    bus.s0_valid = 1'b1; bus.s0_rd = 5'd5; bus.s0_data = 64'hA;
    bus.s1_valid = 1'b1; bus.s1_rd = 5'd6; bus.s1_data = 64'hB;
    for (int i = 0; i < 4; i++) begin
      expect_rdy("alt", (i % 2) == 0, (i % 2) == 1, 1'b0);
      push_src(i % 2);
      next_cyc();
    end

    // dbg starvation guard
    bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd7; bus.dbg_data = 64'h77;
    for (int i = 0; i < 5; i++) begin
      expect_rdy("starve", alt_seq[i] == 0, alt_seq[i] == 1, alt_seq[i] == 2);
      push_src(alt_seq[i]);
      next_cyc();
      if (alt_seq[i] == 2) bus.dbg_valid = 1'b0;
    end
    idle_all();

    // x0 requests complete alongside a real grant
    bus.s0_valid = 1'b1;  bus.s0_rd = 5'd0;  bus.s0_data = 64'hDEAD;
    bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd0; bus.dbg_data = 64'hBEEF;
    bus.s1_valid = 1'b1;  bus.s1_rd = 5'd9;  bus.s1_data = 64'h99;
    expect_rdy("x0", 1'b1, 1'b1, 1'b1);
    push(5'd9, 64'h99);
    next_cyc();
    bus.dbg_valid = 1'b0;
    bus.s0_rd = 5'd10; bus.s0_data = 64'h10A;
    bus.s1_rd = 5'd11; bus.s1_data = 64'h11B;
    expect_rdy("x0_ptr", 1'b1, 1'b0, 1'b0);
    push(5'd10, 64'h10A);
    next_cyc();
    bus.s0_valid = 1'b0;
    expect_rdy("x0_tail", 1'b0, 1'b1, 1'b0);
    push(5'd11, 64'h11B);
    next_cyc();
    idle_all();

    // same rd from both with rr_ptr=1
    bus.s0_valid = 1'b1; bus.s0_rd = 5'd1; bus.s0_data = 64'h1;
    expect_rdy("same_pre", 1'b1, 1'b0, 1'b0);
    push(5'd1, 64'h1);
    next_cyc();
    bus.s0_rd = 5'd3; bus.s0_data = 64'h11;
    bus.s1_valid = 1'b1; bus.s1_rd = 5'd3; bus.s1_data = 64'h22;
    expect_rdy("same_a", 1'b0, 1'b1, 1'b0);
    push(5'd3, 64'h22);
    next_cyc();
    bus.s1_valid = 1'b0;
    expect_rdy("same_b", 1'b1, 1'b0, 1'b0);
    push(5'd3, 64'h11);
    next_cyc();
    idle_all();
    @(negedge clk);
    #1;
    check("x3_final", shadow[3], 64'h11);

    // lone dbg request wins immediately
    next_cyc();
    bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd8; bus.dbg_data = 64'h88;
    expect_rdy("dbg_only", 1'b0, 1'b0, 1'b1);
    push(5'd8, 64'h88);
    next_cyc();
    idle_all();

    // forwarding compare on the pending write
    bus.s0_valid = 1'b1; bus.s0_rd = 5'd4; bus.s0_data = 64'h44;
    expect_rdy("fwd_req", 1'b1, 1'b0, 1'b0);
    push(5'd4, 64'h44);
    next_cyc();
    idle_all();
    bus.fwd_rs1 = 5'd4;
    bus.fwd_rs2 = 5'd0;
    @(negedge clk);
    check("fwd_hit1", 64'(bus.fwd_hit1), 64'(FWD_EXP));
    check("fwd_hit2", 64'(bus.fwd_hit2), 64'd0);
    next_cyc();
    @(negedge clk);
    check("fwd_nowe", 64'(bus.fwd_hit1), 64'd0);

    repeat (2) next_cyc();
    check("q_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
